// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared definitions for the IMEM boot loader:
//   - loader FSM state encoding
//   - default frame start byte
//   - frame field widths
package imem_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int LEN_W  = 16;
  localparam int WORD_W = 32;

  localparam logic [BYTE_W-1:0] MAGIC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } loader_state_t;

  // The loader takes bytes in every state except the two terminal ones.
  function automatic logic is_active(input loader_state_t s);
    return (s != ST_DONE) && (s != ST_ERROR);
  endfunction

endpackage

// File: rtl/imem_loader_word_pack.sv
// loader_word_pack
//   Packs a little-endian byte stream into 32-bit words.
//   Bytes for lanes 0..2 are staged.  The lane-3 byte completes the word,
//   which moves into a separate output register together with a one-cycle
//   word_valid pulse.  Because the output register is separate from the
//   staging register, a back-to-back byte for the next word's lane 0 cannot
//   disturb the word being written.
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   clear      in   return the lane counter to 0 (drops a partial word)
//   byte_in    in   data byte
//   byte_valid in   byte_in is taken this cycle
//   lane       out  lane the next byte will fill
//   word       out  last completed word
//   word_valid out  one-cycle pulse when word is updated
module loader_word_pack
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic [1:0]        lane,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [3*BYTE_W-1:0] stage;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane       <= 2'd0;
      stage      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        lane <= 2'd0;
      end else if (byte_valid) begin
        lane <= lane + 2'd1;
        unique case (lane)
          2'd0: stage[7:0]   <= byte_in;
          2'd1: stage[15:8]  <= byte_in;
          2'd2: stage[23:16] <= byte_in;
          default: begin
            word       <= {byte_in, stage};
            word_valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Byte-stream boot loader.  Accepts frames of the form
//     MAGIC, LEN_LO, LEN_HI, LEN*4 data bytes (LSB first), CSUM
//   writes the data words into instruction memory and releases the core
//   from reset once the XOR checksum over LEN_LO..last data byte matches.
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   in_data      in   incoming byte
//   in_valid     in   in_data valid
//   in_ready     out  loader accepts a byte (registered)
//   load_req     in   re-arm pulse, honoured in DONE/ERROR only
//   imem_we      out  IMEM write strobe, one cycle per word
//   imem_addr    out  IMEM byte address, word aligned
//   imem_wdata   out  IMEM write data
//   cpu_reset_n  out  core reset, high only after a good load (registered)
//   load_done    out  frame loaded, checksum good
//   load_err     out  length overflow or checksum mismatch
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_IDLE  | hunting for MAGIC, other bytes dropped
// ST_LEN0  | waiting for LEN_LO
// ST_LEN1  | waiting for LEN_HI, length range check
// ST_DATA  | receiving data bytes, one IMEM write per 4 bytes
// ST_CHECK | waiting for the checksum byte
// ST_DONE  | good load, core released one cycle after entry
// ST_ERROR | bad length or checksum, core held in reset
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [31:0]       BASE_ADDR = 32'h0,
  parameter logic [BYTE_W-1:0] MAGIC     = MAGIC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_req,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_reset_n,
  output logic              load_done,
  output logic              load_err
);

  localparam int          CNT_W   = ADDR_W + 1;
  localparam int unsigned MAX_LEN = 32'd1 << ADDR_W;

  loader_state_t     state;
  logic [BYTE_W-1:0] len_lo;
  logic [LEN_W-1:0]  len;
  logic [CNT_W-1:0]  word_cnt;
  logic [BYTE_W-1:0] csum;

  logic              accept;
  logic [LEN_W-1:0]  full_len;
  logic              last_word;
  logic [ADDR_W+1:0] word_off;
  logic [1:0]        pk_lane;

  assign accept    = in_valid && in_ready;
  assign full_len  = {in_data, len_lo};
  assign last_word = (32'(word_cnt) + 32'd1) == 32'(len);
  // Dropping the top counter bit makes the address wrap inside the IMEM window.
  assign word_off  = {word_cnt[ADDR_W-1:0], 2'b00};

  loader_word_pack u_pack (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (state != ST_DATA),
    .byte_in    (in_data),
    .byte_valid (accept && (state == ST_DATA)),
    .lane       (pk_lane),
    .word       (imem_wdata),
    .word_valid (imem_we)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      in_ready    <= 1'b0;
      len_lo      <= '0;
      len         <= '0;
      word_cnt    <= '0;
      csum        <= '0;
      imem_addr   <= BASE_ADDR;
      cpu_reset_n <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      in_ready <= is_active(state);
      case (state)
        ST_IDLE: begin
          if (accept && (in_data == MAGIC)) begin
            state <= ST_LEN0;
            csum  <= '0;
          end
        end
        ST_LEN0: begin
          if (accept) begin
            len_lo <= in_data;
            csum   <= csum ^ in_data;
            state  <= ST_LEN1;
          end
        end
        ST_LEN1: begin
          if (accept) begin
            len      <= full_len;
            csum     <= csum ^ in_data;
            word_cnt <= '0;
            if (32'(full_len) > MAX_LEN) begin
              state    <= ST_ERROR;
              in_ready <= 1'b0;
              load_err <= 1'b1;
            end else if (full_len == '0) begin
              state <= ST_CHECK;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (accept) begin
            csum <= csum ^ in_data;
            // The packer raises imem_we on the same edge, so the address
            // is registered here to line up with it.
            if (pk_lane == 2'd3) begin
              imem_addr <= BASE_ADDR + 32'(word_off);
              word_cnt  <= word_cnt + CNT_W'(1);
              if (last_word) begin
                state <= ST_CHECK;
              end
            end
          end
        end
        ST_CHECK: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state     <= ST_DONE;
              load_done <= 1'b1;
            end else begin
              state    <= ST_ERROR;
              load_err <= 1'b1;
            end
          end
        end
        ST_DONE, ST_ERROR: begin
          if (load_req) begin
            state       <= ST_IDLE;
            in_ready    <= 1'b1;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
            cpu_reset_n <= 1'b0;
            len         <= '0;
            word_cnt    <= '0;
            csum        <= '0;
          end else begin
            cpu_reset_n <= (state == ST_DONE);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
